// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin arbiter that funnels register-file write requests from
// NUM_REQ requesters onto a single registered write port. It also
// sequences changes of the active register bank so that a bank change
// never coincides with a write.
//
// Writes to the read-only addresses (RO_BASE and above: SP, SR, PC) are
// accepted so the requester is not stalled. They are then dropped, and a
// one-cycle ro_violation pulse is raised instead.
//
// Bank switching is a three-state sequence:
//   RUN    : normal arbitration.
//   DRAIN  : one idle cycle. The write registered in the last RUN cycle
//            lands on the old bank.
//   SWITCH : bank_select takes bank_next and bank_ack pulses.
//
// Ports
//   clock         in   sole clock, rising edge
//   reset         in   asynchronous, active-high reset
//   req_valid     in   [NUM_REQ]          per-requester write request
//   req_addr      in   [NUM_REQ*ADDR_W]   requester i at [i*ADDR_W +: ADDR_W]
//   req_data      in   [NUM_REQ*DATA_W]   requester i at [i*DATA_W +: DATA_W]
//   req_ready     out  [NUM_REQ]          one-hot/zero accept strobe
//   bank_req      in   level request to change the active bank
//   bank_next     in   [2]  bank to switch to, sampled at the commit edge
//   bank_ack      out  one-cycle pulse while bank_select shows the new bank
//   bank_select   out  [2]  active bank
//   write_addr    out  [ADDR_W]  register file write address
//   write_data    out  [DATA_W]  register file write data
//   write_en      out  register file write strobe
//   ro_violation  out  pulse after an accepted write to a read-only address
//   grant_id      out  [2]  requester whose write is presented
//
// grant_id is 2 bits wide, so NUM_REQ may be at most 4.
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int RO_BASE = 13
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        bank_req,
  input  logic [1:0]                  bank_next,
  output logic                        bank_ack,
  output logic [1:0]                  bank_select,
  output logic [ADDR_W-1:0]           write_addr,
  output logic [DATA_W-1:0]           write_data,
  output logic                        write_en,
  output logic                        ro_violation,
  output logic [1:0]                  grant_id
);

  // If RO_BASE does not fit in the address space, no address is read-only.
  localparam bit               HAS_RO    = (RO_BASE < (1 << ADDR_W));
  localparam logic [ADDR_W-1:0] RO_BASE_A = ADDR_W'(RO_BASE);
  localparam logic [1:0]        LAST_RST  = 2'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic [1:0]          bank_select_q, bank_select_d;
  logic                bank_ack_q, bank_ack_d;
  logic                write_en_q, write_en_d;
  logic                ro_violation_q, ro_violation_d;
  logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [1:0]          grant_id_q, grant_id_d;

  // Arbitration results.
  logic [1:0]          grant_idx;
  logic                grant_found;
  logic                handshake;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_is_ro;

  // ---------------------------------------------------------------------------
  // Round-robin search. It starts one past the last granted requester, and
  // the first valid requester found wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_idx   = last_grant_q;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(idx);
      end
    end
  end

  // Grants are offered only in RUN and only while no bank change is
  // pending. A pending bank change must see a write-free cycle first.
  always_comb begin
    req_ready = '0;
    handshake = 1'b0;
    if (state_q == ST_RUN && !bank_req && grant_found) begin
      req_ready[grant_idx] = 1'b1;
      handshake            = 1'b1;
    end
  end

  always_comb begin
    sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    sel_is_ro = HAS_RO && (sel_addr >= RO_BASE_A);
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    bank_select_d  = bank_select_q;
    bank_ack_d     = 1'b0;
    write_en_d     = 1'b0;
    ro_violation_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    grant_id_d     = grant_id_q;

    if (handshake) begin
      last_grant_d = grant_idx;
      if (sel_is_ro) begin
        // Accepted so the requester moves on. The write is suppressed and
        // the write port keeps its last contents.
        ro_violation_d = 1'b1;
      end else begin
        write_en_d   = 1'b1;
        write_addr_d = sel_addr;
        write_data_d = sel_data;
        grant_id_d   = grant_idx;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (bank_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The bank is committed on the edge into SWITCH. Nothing is granted
        // in DRAIN, so write_en is low in the cycle the bank changes.
        state_d       = ST_SWITCH;
        bank_select_d = bank_next;
        bank_ack_d    = 1'b1;
      end
      ST_SWITCH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      last_grant_q   <= LAST_RST;
      bank_select_q  <= 2'd0;
      bank_ack_q     <= 1'b0;
      write_en_q     <= 1'b0;
      ro_violation_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      grant_id_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      bank_select_q  <= bank_select_d;
      bank_ack_q     <= bank_ack_d;
      write_en_q     <= write_en_d;
      ro_violation_q <= ro_violation_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      grant_id_q     <= grant_id_d;
    end
  end

  assign bank_select  = bank_select_q;
  assign bank_ack     = bank_ack_q;
  assign write_en     = write_en_q;
  assign ro_violation = ro_violation_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Directed bench for reg_write_arbiter with the default parameters:
// 3 requesters, 16-bit data, 4-bit addresses, and read-only from address 13.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;

  logic                       clock;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       bank_req;
  logic [1:0]                 bank_next;
  logic                       bank_ack;
  logic [1:0]                 bank_select;
  logic [ADDR_W-1:0]          write_addr;
  logic [DATA_W-1:0]          write_data;
  logic                       write_en;
  logic                       ro_violation;
  logic [1:0]                 grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  reg_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RO_BASE(13)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .bank_req(bank_req), .bank_next(bank_next), .bank_ack(bank_ack),
    .bank_select(bank_select),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .ro_violation(ro_violation), .grant_id(grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs are driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    bank_req  = 1'b0;
    bank_next = 2'd0;
    tick();
    tick();

    // Reset state
    chk("rst_write_en",   32'(write_en),     32'h0);
    chk("rst_ro",         32'(ro_violation), 32'h0);
    chk("rst_bank_ack",   32'(bank_ack),     32'h0);
    chk("rst_bank_sel",   32'(bank_select),  32'h0);
    chk("rst_waddr",      32'(write_addr),   32'h0);
    chk("rst_wdata",      32'(write_data),   32'h0);
    chk("rst_grant_id",   32'(grant_id),     32'h0);
    reset = 1'b0;
    #1;
    chk("idle_ready",     32'(req_ready),    32'h0);

    // All three requesters valid: grants rotate 0,1,2,0
    set_req(0, 4'd1, 16'h1111);
    set_req(1, 4'd2, 16'h2222);
    set_req(2, 4'd3, 16'h3333);
    tick();
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = k % 3;
      chk("rr_ready", 32'(req_ready), 32'(1 << g));
      tick();
      chk("rr_wen",   32'(write_en),   32'h1);
      chk("rr_waddr", 32'(write_addr), 32'(g + 1));
      chk("rr_wdata", 32'(write_data), 32'(16'h1111 * (g + 1)));
      chk("rr_gid",   32'(grant_id),   32'(g));
    end
    req_valid = 3'b000;
    #1;
    chk("drop_ready", 32'(req_ready), 32'h0);
    tick();
    chk("idle_wen", 32'(write_en),     32'h0);
    chk("idle_ro",  32'(ro_violation), 32'h0);

    // Requester 1 writes addr 4, data 002A
    set_req(1, 4'd4, 16'h002A);
    req_valid = 3'b010;
    #1;
    chk("r1_ready", 32'(req_ready), 32'h2);
    tick();
    chk("r1_wen",   32'(write_en),   32'h1);
    chk("r1_waddr", 32'(write_addr), 32'h4);
    chk("r1_wdata", 32'(write_data), 32'h2A);
    chk("r1_gid",   32'(grant_id),   32'h1);
    req_valid = 3'b000;

    // Requester 0 writes read-only addr 14, then addr 3
    set_req(0, 4'd14, 16'hBEEF);
    req_valid = 3'b001;
    #1;
    chk("ro_ready", 32'(req_ready), 32'h1);
    tick();
    chk("ro_wen",        32'(write_en),     32'h0);
    chk("ro_pulse",      32'(ro_violation), 32'h1);
    chk("ro_waddr_hold", 32'(write_addr),   32'h4);
    chk("ro_wdata_hold", 32'(write_data),   32'h2A);
    set_req(0, 4'd3, 16'h0033);
    tick();
    chk("r0b_wen",   32'(write_en),     32'h1);
    chk("r0b_ro",    32'(ro_violation), 32'h0);
    chk("r0b_waddr", 32'(write_addr),   32'h3);
    chk("r0b_wdata", 32'(write_data),   32'h33);
    chk("r0b_gid",   32'(grant_id),     32'h0);
    req_valid = 3'b000;

    // Bank switch to 2 while requester 2 has a write in flight
    set_req(2, 4'd7, 16'h0777);
    req_valid = 3'b100;
    #1;
    chk("bk_ready0", 32'(req_ready), 32'h4);
    tick();
    bank_req  = 1'b1;
    bank_next = 2'd2;
    #1;
    chk("bk_inflight_wen",  32'(write_en),    32'h1);
    chk("bk_inflight_addr", 32'(write_addr),  32'h7);
    chk("bk_inflight_bank", 32'(bank_select), 32'h0);
    chk("bk_req_ready",     32'(req_ready),   32'h0);
    tick();
    chk("drain_wen",   32'(write_en),    32'h0);
    chk("drain_ready", 32'(req_ready),   32'h0);
    chk("drain_bank",  32'(bank_select), 32'h0);
    chk("drain_ack",   32'(bank_ack),    32'h0);
    tick();
    chk("sw_bank",  32'(bank_select), 32'h2);
    chk("sw_ack",   32'(bank_ack),    32'h1);
    chk("sw_wen",   32'(write_en),    32'h0);
    bank_req = 1'b0;
    #1;
    chk("sw_ready", 32'(req_ready),   32'h0);
    tick();
    chk("run_ack",   32'(bank_ack),    32'h0);
    chk("run_bank",  32'(bank_select), 32'h2);
    chk("run_ready", 32'(req_ready),   32'h4);

    // Only requester 2 valid, continuous
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r2c_wen",   32'(write_en),   32'h1);
      chk("r2c_gid",   32'(grant_id),   32'h2);
      chk("r2c_waddr", 32'(write_addr), 32'h7);
      chk("r2c_ready", 32'(req_ready),  32'h4);
    end
    req_valid = 3'b000;
    tick();

    // Reset pulsed during DRAIN aborts the switch
    bank_req  = 1'b1;
    bank_next = 2'd3;
    tick();
    chk("rd_drain_ack", 32'(bank_ack),    32'h0);
    chk("rd_drain_sel", 32'(bank_select), 32'h2);
    reset = 1'b1;
    #1;
    chk("rd_async_sel", 32'(bank_select), 32'h0);
    chk("rd_async_ack", 32'(bank_ack),    32'h0);
    bank_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rd_post_ack", 32'(bank_ack),    32'h0);
    chk("rd_post_sel", 32'(bank_select), 32'h0);
    set_req(0, 4'd5, 16'h0055);
    req_valid = 3'b001;
    #1;
    chk("rd_run_ready", 32'(req_ready), 32'h1);
    tick();
    chk("rd_ack_never", 32'(bank_ack),   32'h0);
    chk("rd_wen",       32'(write_en),   32'h1);
    chk("rd_waddr",     32'(write_addr), 32'h5);
    chk("rd_gid",       32'(grant_id),   32'h0);

    // A write about to be accepted when reset asserts is discarded
    set_req(1, 4'd6, 16'h0066);
    req_valid = 3'b010;
    #1;
    chk("rw_ready", 32'(req_ready), 32'h2);
    reset = 1'b1;
    #1;
    chk("rw_wen_async", 32'(write_en), 32'h0);
    tick();
    chk("rw_wen_held",  32'(write_en),   32'h0);
    chk("rw_waddr",     32'(write_addr), 32'h0);
    req_valid = 3'b000;
    reset = 1'b0;
    tick();
    chk("rw_wen_after", 32'(write_en), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of write requesters.
REQ-002 SHALL have parameter DATA_W, default 16: register data width.
REQ-003 SHALL have parameter ADDR_W, default 4: register address width.
REQ-004 SHALL have parameter RO_BASE, default 13: first read-only address (SP=13, SR=14, PC=15).
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  per-requester target register; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot or zero; accept strobe per requester.
REQ-011 SHALL have port bank_req  input  1  request to change the active register bank.
REQ-012 SHALL have port bank_next  input  2  bank to switch to; sampled when the switch commits.
REQ-013 SHALL have port bank_ack  output  1  one-cycle pulse when the bank switch commits.
REQ-014 SHALL have port bank_select  output  2  active bank, driven to the register file.
REQ-015 SHALL have port write_addr  output  ADDR_W  register file write address.
REQ-016 SHALL have port write_data  output  DATA_W  register file write data.
REQ-017 SHALL have port write_en  output  1  register file write strobe.
REQ-018 SHALL have port ro_violation  output  1  one-cycle pulse on an accepted write to a read-only address.
REQ-019 SHALL have port grant_id  output  2  index of the requester accepted in the previous cycle.

Function
REQ-020 SHALL implement states RUN, DRAIN and SWITCH.
REQ-021 In RUN with bank_req=0, SHALL raise req_ready for exactly one valid requester, chosen combinationally by round-robin starting at last_grant+1 mod NUM_REQ.
REQ-022 A handshake on requester i SHALL occur when req_valid[i] and req_ready[i] are both high; last_grant then becomes i.
REQ-023 req_ready SHALL be all-zero when no req_valid is high, in DRAIN and SWITCH, and in RUN while bank_req=1.
REQ-024 A handshake at cycle N with addr < RO_BASE SHALL produce write_en=1 with that addr and data at cycle N+1 (registered, latency 1).
REQ-025 A handshake with addr >= RO_BASE SHALL complete normally and advance last_grant; at N+1, write_en=0 and ro_violation=1.
REQ-026 write_en and ro_violation SHALL be 0 in any cycle not preceded by a handshake.
REQ-027 write_addr, write_data and grant_id SHALL hold their last values when write_en=0.
REQ-028 RUN SHALL go to DRAIN when bank_req=1; no handshake is accepted in that cycle.
REQ-029 DRAIN SHALL last exactly one cycle, letting any write registered in the previous cycle complete on the old bank, then go to SWITCH.
REQ-030 SWITCH SHALL load bank_select from bank_next, pulse bank_ack for that one cycle, and return to RUN.
REQ-031 bank_req SHALL be a level; if still high on return to RUN, a further DRAIN/SWITCH cycle SHALL start. Requesters deassert it on bank_ack.
REQ-032 bank_select SHALL change only on the SWITCH edge; no write_en SHALL be high in the cycle bank_select changes.
REQ-033 Requests SHALL never be dropped; a requester holding req_valid high is served within NUM_REQ handshakes while bank_req is low.

Reset
REQ-034 reset=1 SHALL asynchronously force state=RUN, last_grant=NUM_REQ-1, bank_select=0, write_en=0, ro_violation=0, bank_ack=0, write_addr=0, write_data=0, grant_id=0.
REQ-035 A write registered in the cycle reset asserts SHALL be discarded; write_en SHALL be 0 from the first post-reset cycle.
REQ-036 Reset during DRAIN or SWITCH SHALL abort the switch: bank_select=0, no bank_ack.

Verification
REQ-037 After reset, req_valid=3'b111 held -> grants 0,1,2,0; write_en one cycle after each grant with the matching addr and data.
REQ-038 Requester 1 writes addr 4, data 16'h002A -> next cycle write_en=1, write_addr=4, write_data=16'h002A, grant_id=1.
REQ-039 Requester 0 writes addr 14 -> next cycle write_en=0, ro_violation=1; a later write from requester 0 to addr 3 proceeds.
REQ-040 bank_req=1, bank_next=2 while requester 2 writes -> in-flight write completes on bank 0; DRAIN; SWITCH gives bank_select=2 and bank_ack=1; grants resume the next cycle.
REQ-041 Reset pulsed during DRAIN -> bank_select=0, bank_ack never pulses, state=RUN.
REQ-042 Only requester 2 valid, continuous -> grants to 2 every cycle, write_en high each cycle after the first.
